// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC engines: default sizes, FSM state encoding
// and Q2.30 constants used by callers for pre-scaling and angle ranges.
package cordic_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ITERS  = 16;
  localparam int DEF_ADDR_W = 4;

  typedef enum logic [1:0] {IDLE, LOAD, ITER, DONE} state_t;

  localparam logic [31:0] CORDIC_GAIN = 32'h26DD3B6A;
  localparam logic [31:0] ANGLE_PI_4  = 32'h3243F6A8;
  localparam logic [31:0] ANGLE_PI_2  = 32'h6487ED51;
endpackage

// File: rtl/cordic_iter_core_if.sv
// Operand/result handshake between the angle front end (master) and the core (slave).
interface cordic_iter_core_if import cordic_pkg::*; #(parameter int DATA_W = DEF_DATA_W);
  logic              start;
  logic [DATA_W-1:0] x_in, y_in, z_in;
  logic              busy, done;
  logic [DATA_W-1:0] x_out, y_out, z_out;

  modport master (output start, x_in, y_in, z_in,
                  input  busy, done, x_out, y_out, z_out);
  modport slave  (input  start, x_in, y_in, z_in,
                  output busy, done, x_out, y_out, z_out);
endinterface

// File: rtl/cordic_microrot.sv
// One combinational rotation-mode CORDIC step; direction follows the sign of z.
module cordic_microrot import cordic_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int IDX_W  = DEF_ADDR_W
) (
  input  logic signed [DATA_W-1:0] x,
  input  logic signed [DATA_W-1:0] y,
  input  logic signed [DATA_W-1:0] z,
  input  logic        [IDX_W-1:0]  i,
  input  logic signed [DATA_W-1:0] atan,
  output logic signed [DATA_W-1:0] x_nxt,
  output logic signed [DATA_W-1:0] y_nxt,
  output logic signed [DATA_W-1:0] z_nxt
);
  logic signed [DATA_W-1:0] xs, ys;

  assign xs = x >>> i;
  assign ys = y >>> i;

  always_comb begin
    if (z[DATA_W-1]) begin
      x_nxt = x + ys;
      y_nxt = y - xs;
      z_nxt = z + atan;
    end else begin
      x_nxt = x - ys;
      y_nxt = y + xs;
      z_nxt = z - atan;
    end
  end
endmodule

// File: rtl/cordic_iter_core.sv
// Iterative rotation-mode CORDIC: one micro-rotation per clock, fed by a
// synchronous arctan ROM whose address is kept one step ahead of the datapath.
module cordic_iter_core import cordic_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ITERS  = DEF_ITERS,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  cordic_iter_core_if.slave io,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data
);
  state_t state, state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic signed [DATA_W-1:0] x_r, y_r, z_r, x_n, y_n, z_n;
  logic last;

  assign last = (cnt == ADDR_W'(ITERS-1));

  cordic_microrot #(.DATA_W(DATA_W), .IDX_W(ADDR_W)) u_rot (
    .x(x_r), .y(y_r), .z(z_r), .i(cnt), .atan(rom_data),
    .x_nxt(x_n), .y_nxt(y_n), .z_nxt(z_n)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    io.busy   = 1'b0;
    io.done   = 1'b0;
    case (state)
      IDLE: if (io.start) state_nxt = LOAD;
      LOAD: begin
        io.busy   = 1'b1;
        state_nxt = ITER;
      end
      ITER: begin
        io.busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        io.done   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // rom_addr leads cnt by one so rom_data in ITER cycle i is atan(2^-i);
  // the final increment wraps and that word is never consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      rom_addr <= '0;
      x_r      <= '0;
      y_r      <= '0;
      z_r      <= '0;
      io.x_out <= '0;
      io.y_out <= '0;
      io.z_out <= '0;
    end else begin
      case (state)
        IDLE: if (io.start) begin
          x_r      <= io.x_in;
          y_r      <= io.y_in;
          z_r      <= io.z_in;
          cnt      <= '0;
          rom_addr <= '0;
        end
        LOAD: begin
          cnt      <= '0;
          rom_addr <= ADDR_W'(1);
        end
        ITER: begin
          x_r      <= x_n;
          y_r      <= y_n;
          z_r      <= z_n;
          cnt      <= cnt + ADDR_W'(1);
          rom_addr <= cnt + ADDR_W'(2);
          if (last) begin
            io.x_out <= x_n;
            io.y_out <= y_n;
            io.z_out <= z_n;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
